cell_bist_ctrl: RTL and testbench
=================================

# cell_bist_ctrl

Built-in self-test controller for the high-speed standard-cell library. It drives pseudo-random stimulus into a cell-under-test (CUT) and compacts the CUT's responses into a signature. At the end of the run it compares that signature against a golden value. It sits on the silicon characterization tile, one instance per group of combinational cells.

## Interface
Parameters:
- PATTERNS, 255: number of stimulus patterns per run; legal range 1..255.
- SETTLE, 0: extra hold cycles per pattern before capture; legal range 0..15.
- GOLDEN, 8'h00: expected final signature.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET_B  input  1  reset, asynchronous, active-low.
- VPWR, VGND, VPB, VNB  input  1 each  power/bulk pins; no logic function.
- START  input  1  launches a run; sampled in IDLE and DONE only.
- ABORT  input  1  cancels a run in progress.
- RESP  input  8  CUT response bus; CUT is combinational from STIM.
- STIM  output  8  stimulus to the CUT.
- BUSY  output  1  high in RUN.
- DONE  output  1  high in DONE.
- PASS  output  1  valid only while DONE is high; 1 when SIGNATURE == GOLDEN.
- SIGNATURE  output  8  current MISR contents.

## Operation
- States:
  - IDLE: reset state.
  - RUN: stimulus is applied and responses are compacted.
  - DONE: the result is held.
- State transitions:
  - IDLE -> RUN on START.
  - RUN -> DONE after the last capture.
  - RUN -> IDLE on ABORT.
  - DONE -> RUN on START.
  - DONE -> IDLE on ABORT.
  - START is ignored in RUN. ABORT has priority over START.
- Stimulus LFSR (Fibonacci, x^8+x^6+x^5+x^4+1):
  - Next value = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Seed is 8'h01, loaded on entry to RUN. Period is 255 and the value is never 8'h00.
  - STIM = lfsr in RUN and 8'h00 otherwise.
- MISR:
  - Cleared to 8'h00 on entry to RUN.
  - Capture: misr <= {misr[6:0], misr[7]^misr[5]^misr[4]^misr[3]} ^ RESP.
- Each pattern is held for SETTLE+1 cycles, counted by a hold counter.
  - On the last hold cycle, RESP is captured into the MISR.
  - On that same edge, the LFSR advances and the pattern counter increments.
- After capture number PATTERNS, the state becomes DONE on that same edge.
  - The LFSR and MISR freeze.
  - PASS = (misr == GOLDEN), registered on that edge.
- All counters are sized for the maximum parameter values. The pattern counter does not wrap within a run.
- Reset values (RESET_B low, any time including mid-run):
  - State = IDLE.
  - STIM = 8'h00, BUSY = 0, DONE = 0, PASS = 0, SIGNATURE = 8'h00.
  - All counters = 0, LFSR = 8'h01.

## Timing
- START high at edge N (state IDLE or DONE):
  - From edge N, BUSY = 1 and STIM = 8'h01.
  - DONE = 0 and SIGNATURE = 8'h00.
- Captures occur at edges N + k*(SETTLE+1), for k = 1..PATTERNS.
- DONE and PASS rise at edge N + PATTERNS*(SETTLE+1); BUSY falls on the same edge.
- RESP must be stable one cycle after STIM changes. The CUT path is budgeted at less than one CLK period when SETTLE=0.
- ABORT high at any edge in RUN:
  - Next state is IDLE and BUSY = 0.
  - DONE stays 0 and the MISR keeps its partial value.
- DONE holds indefinitely until START, ABORT, or reset.
- Restart from DONE re-seeds the LFSR and clears the MISR. The first new STIM (8'h01) is visible the cycle after START.
- Deassertion of RESET_B is synchronized externally; the first START is accepted one cycle after release.

## Test plan
- Reset mid-run: pulse RESET_B low during RUN at pattern 10 -> all outputs return to reset values immediately (asynchronous). After release, START begins a fresh run at STIM=8'h01.
- Stimulus sequence: PATTERNS=255, SETTLE=0, RESP tied 8'h00, START at edge 0 ->
  - STIM sequence is 01,02,04,08,10,21,...
  - All 255 values are distinct and no 00 appears.
  - DONE at edge 255; SIGNATURE=8'h00; PASS=1 with GOLDEN=8'h00.
- Buffer CUT with mutation: RESP=STIM (buffer CUT), GOLDEN set to the model-computed signature -> PASS=1. Flipping RESP[3] on capture 100 only -> PASS=0 and SIGNATURE differs from GOLDEN.
- SETTLE timing: SETTLE=3, PATTERNS=4 -> each STIM value is held 4 cycles, BUSY is high for exactly 16 cycles, and DONE rises at edge 16.
- ABORT mid-run: ABORT at capture 50 -> IDLE next edge, DONE=0, STIM=00. START in RUN is ignored: the run length is unchanged.
- Restart from DONE: START while DONE=1 -> DONE drops, SIGNATURE clears to 00, and the second run's signature equals the first.

Source files
------------

// File: rtl/cell_bist_ctrl.sv
// BIST controller: LFSR stimulus into a combinational cell-under-test, MISR
// compaction of its responses, and a golden-signature compare at end of run.
//
// state  | meaning
// IDLE   | waiting for START; STIM parked at 00
// RUN    | patterns applied, responses captured every SETTLE+1 cycles
// DONE   | signature and PASS held until START, ABORT or reset
module cell_bist_ctrl #(
  parameter int unsigned PATTERNS = 255,
  parameter int unsigned SETTLE   = 0,
  parameter logic [7:0]  GOLDEN   = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       VPWR,
  input  logic       VGND,
  input  logic       VPB,
  input  logic       VNB,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] RESP,
  output logic [7:0] STIM,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] SIGNATURE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [7:0] LAST_PAT  = 8'(PATTERNS - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(SETTLE);

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] misr_q, misr_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] pat_q, pat_d;
  logic       pass_q, pass_d;
  logic [7:0] misr_cap;
  logic [7:0] lfsr_nxt;
  logic       unused_pwr;

  // Power and bulk pins exist only for the netlist; they carry no logic.
  assign unused_pwr = VPWR ^ VGND ^ VPB ^ VNB;

  assign misr_cap = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]} ^ RESP;
  assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q <= S_IDLE;
      lfsr_q  <= 8'h01;
      misr_q  <= 8'h00;
      hold_q  <= 4'd0;
      pat_q   <= 8'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      hold_q  <= hold_d;
      pat_q   <= pat_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    hold_d  = hold_q;
    pat_d   = pat_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ABORT) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (START) begin
          state_d = S_RUN;
          lfsr_d  = 8'h01;
          misr_d  = 8'h00;
          hold_d  = HOLD_LOAD;
          pat_d   = 8'd0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        // An abort wins over a capture due on the same edge, so the MISR
        // keeps exactly the captures completed before the abort.
        if (ABORT) begin
          state_d = S_IDLE;
        end else if (hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
        end else begin
          misr_d = misr_cap;
          lfsr_d = lfsr_nxt;
          hold_d = HOLD_LOAD;
          pat_d  = pat_q + 8'd1;
          if (pat_q == LAST_PAT) begin
            state_d = S_DONE;
            pass_d  = (misr_cap == GOLDEN);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign STIM      = (state_q == S_RUN) ? lfsr_q : 8'h00;
  assign BUSY      = (state_q == S_RUN);
  assign DONE      = (state_q == S_DONE);
  assign PASS      = pass_q;
  assign SIGNATURE = misr_q;

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Scoreboard bench for cell_bist_ctrl: three instances with different
// parameters, a behavioural CUT, and a monitor that checks each run's end.
module tb_cell_bist_ctrl;

  localparam int NI = 3;

  typedef struct {
    logic       is_abort;
    logic [7:0] sig;
    logic       pass;
    int         cycles;
  } exp_t;

  function automatic logic [7:0] cut(int mode, logic [7:0] key, logic [7:0] s);
    case (mode)
      0:       return 8'h00;
      1:       return s;
      2:       return {s[3:0], s[7:4]} ^ key;
      default: return s + key;
    endcase
  endfunction

  // Reference: walk the stimulus sequence, fold each response into the MISR.
  function automatic logic [7:0] exp_sig(int npat, int mode, logic [7:0] key, int mut);
    logic [7:0] s;
    logic [7:0] m;
    logic [7:0] r;
    s = 8'h01;
    m = 8'h00;
    for (int k = 0; k < npat; k++) begin
      r = cut(mode, key, s) ^ ((k == mut) ? 8'h08 : 8'h00);
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ r;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    return m;
  endfunction

  localparam int unsigned PAT [NI] = '{255, 255, 4};
  localparam int unsigned SET [NI] = '{0, 0, 3};
  localparam logic [7:0]  GLD [NI] = '{8'h00, exp_sig(255, 1, 8'h00, -1), exp_sig(4, 1, 8'h00, -1)};

  logic       CLK;
  logic       RESET_B;
  logic       start_s  [NI];
  logic       abort_s  [NI];
  logic [7:0] resp_s   [NI];
  logic [7:0] stim_s   [NI];
  logic       busy_s   [NI];
  logic       done_s   [NI];
  logic       pass_s   [NI];
  logic [7:0] sig_s    [NI];
  int         mode_s   [NI];
  logic [7:0] key_s    [NI];
  logic       mut_en   [NI];
  logic [7:0] mut_val  [NI];
  logic [7:0] seq      [255];
  exp_t       exp_q    [NI][$];

  int         checks;
  int         errors;
  int         cnt      [NI];
  int         age      [NI];
  logic       prev_busy[NI];
  logic       prev_done[NI];
  logic       stim_ok  [NI];
  logic [7:0] held_sig [NI];
  logic       held_pass[NI];
  int         mon_idx;
  exp_t       mon_e;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cell_bist_ctrl #(.PATTERNS(PAT[g]), .SETTLE(SET[g]), .GOLDEN(GLD[g])) u_dut (
      .CLK(CLK), .RESET_B(RESET_B),
      .VPWR(1'b1), .VGND(1'b0), .VPB(1'b1), .VNB(1'b0),
      .START(start_s[g]), .ABORT(abort_s[g]), .RESP(resp_s[g]),
      .STIM(stim_s[g]), .BUSY(busy_s[g]), .DONE(done_s[g]),
      .PASS(pass_s[g]), .SIGNATURE(sig_s[g])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Combinational CUT; the optional mutation flips RESP[3] for one pattern.
  always_comb begin
    for (int g = 0; g < NI; g++) begin
      resp_s[g] = cut(mode_s[g], key_s[g], stim_s[g]);
      if (mut_en[g] && busy_s[g] && stim_s[g] == mut_val[g]) resp_s[g] = resp_s[g] ^ 8'h08;
    end
  end

  function automatic void chk(string name, int g, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s inst%0d got %0h want %0h", name, g, got, want);
    end
  endfunction

  function automatic void fail_evt(string name, int g);
    checks++;
    errors++;
    $display("FAIL %s inst%0d got event want none", name, g);
  endfunction

  always @(negedge CLK) begin
    for (int g = 0; g < NI; g++) begin
      if (!RESET_B) begin
        chk("reset_vals", g, {stim_s[g], sig_s[g], busy_s[g], done_s[g], pass_s[g]}, 0);
        prev_busy[g] = 1'b0;
        prev_done[g] = 1'b0;
        cnt[g] = 0;
      end else begin
        if (busy_s[g] && !prev_busy[g]) begin
          chk("run_entry", g, {sig_s[g], done_s[g], pass_s[g]}, 0);
          cnt[g] = 0;
          stim_ok[g] = 1'b1;
        end
        if (busy_s[g]) begin
          mon_idx = cnt[g] / int'(SET[g] + 1);
          if (mon_idx >= 255) stim_ok[g] = 1'b0;
          else if (stim_s[g] != seq[mon_idx]) stim_ok[g] = 1'b0;
          cnt[g]++;
        end
        if (done_s[g] && prev_done[g])
          chk("done_hold", g, {sig_s[g], pass_s[g]}, {held_sig[g], held_pass[g]});
        if (done_s[g] && !prev_done[g]) begin
          held_sig[g] = sig_s[g];
          held_pass[g] = pass_s[g];
          if (exp_q[g].size() == 0) fail_evt("unexpected_done", g);
          else begin
            mon_e = exp_q[g].pop_front();
            age[g] = 0;
            chk("end_kind", g, int'(mon_e.is_abort), 0);
            chk("signature", g, sig_s[g], mon_e.sig);
            chk("pass", g, pass_s[g], mon_e.pass);
            chk("run_cycles", g, cnt[g], mon_e.cycles);
            chk("stim_seq", g, stim_ok[g], 1);
            chk("stim_idle", g, {stim_s[g], busy_s[g]}, 0);
          end
        end
        if (!busy_s[g] && prev_busy[g] && !done_s[g]) begin
          if (exp_q[g].size() == 0) fail_evt("unexpected_abort", g);
          else begin
            mon_e = exp_q[g].pop_front();
            age[g] = 0;
            chk("end_kind", g, int'(mon_e.is_abort), 1);
            chk("abort_sig", g, sig_s[g], mon_e.sig);
            chk("abort_cycles", g, cnt[g], mon_e.cycles);
            chk("abort_outs", g, {stim_s[g], done_s[g], pass_s[g]}, 0);
            chk("stim_seq", g, stim_ok[g], 1);
          end
        end
        if (!done_s[g] && prev_done[g] && !busy_s[g])
          chk("done_abort_outs", g, {stim_s[g], pass_s[g]}, 0);
        prev_busy[g] = busy_s[g];
        prev_done[g] = done_s[g];
        if (exp_q[g].size() != 0) begin
          age[g]++;
          if (age[g] > int'(PAT[g] * (SET[g] + 1)) + 64) begin
            fail_evt("timeout", g);
            void'(exp_q[g].pop_front());
            age[g] = 0;
          end
        end else begin
          age[g] = 0;
        end
      end
    end
  end

  task automatic wait_drain(int g);
    int guard = 0;
    while (exp_q[g].size() != 0 && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
  endtask

  task automatic launch(int g, int mode, logic [7:0] key, int mut, int abort_at, int restart_at);
    exp_t e;
    mode_s[g]  = mode;
    key_s[g]   = key;
    mut_en[g]  = (mut >= 0);
    mut_val[g] = (mut >= 0) ? seq[mut] : 8'h00;
    if (abort_at > 0) begin
      e.is_abort = 1'b1;
      e.sig      = exp_sig(abort_at, mode, key, mut);
      e.pass     = 1'b0;
      e.cycles   = abort_at + 1;
    end else begin
      e.is_abort = 1'b0;
      e.sig      = exp_sig(int'(PAT[g]), mode, key, mut);
      e.pass     = (e.sig == GLD[g]);
      e.cycles   = int'(PAT[g] * (SET[g] + 1));
    end
    exp_q[g].push_back(e);
    @(posedge CLK); #1 start_s[g] = 1'b1;
    @(posedge CLK); #1 start_s[g] = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge CLK);
      #1 abort_s[g] = 1'b1;
      @(posedge CLK); #1 abort_s[g] = 1'b0;
    end
    if (restart_at > 0) begin
      repeat (restart_at) @(posedge CLK);
      #1 start_s[g] = 1'b1;
      @(posedge CLK); #1 start_s[g] = 1'b0;
    end
    wait_drain(g);
  endtask

  initial begin
    logic [7:0] s;
    int gi;
    int mut;
    logic [7:0] k0;
    checks = 0;
    errors = 0;
    RESET_B = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start_s[g] = 1'b0; abort_s[g] = 1'b0; mode_s[g] = 0; key_s[g] = 8'h00;
      mut_en[g] = 1'b0; mut_val[g] = 8'h00; cnt[g] = 0; age[g] = 0;
      prev_busy[g] = 1'b0; prev_done[g] = 1'b0; stim_ok[g] = 1'b1;
      held_sig[g] = 8'h00; held_pass[g] = 1'b0;
    end
    s = 8'h01;
    for (int i = 0; i < 255; i++) begin
      seq[i] = s;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    repeat (3) @(posedge CLK);
    #1 RESET_B = 1'b1;

    launch(0, 0, 8'h00, -1, 0, 0);                 // tied-zero RESP: sig 00, PASS 1
    k0 = 8'($urandom_range(0, 255));
    launch(0, 2, k0, -1, 0, 0);                    // restart from DONE
    launch(0, 2, k0, -1, 0, 0);                    // same run again, same signature
    launch(1, 1, 8'h00, -1, 0, 0);                 // buffer CUT matches golden
    launch(1, 1, 8'h00, 99, 0, 0);                 // RESP[3] flipped on capture 100
    launch(2, 1, 8'h00, -1, 0, 0);                 // SETTLE=3, PATTERNS=4
    launch(2, 3, 8'($urandom_range(0, 255)), -1, 0, 0);
    @(posedge CLK); #1 abort_s[2] = 1'b1;          // DONE -> IDLE on ABORT
    @(posedge CLK); #1 abort_s[2] = 1'b0;
    launch(0, 3, 8'($urandom_range(0, 255)), -1, 0, 30);  // START in RUN ignored
    launch(0, 2, 8'($urandom_range(0, 255)), -1, 50, 0);  // ABORT after capture 50

    // Asynchronous reset in the middle of pattern 10.
    mode_s[0] = 1; mut_en[0] = 1'b0;
    @(posedge CLK); #1 start_s[0] = 1'b1;
    @(posedge CLK); #1 start_s[0] = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RESET_B = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1 RESET_B = 1'b1;
    launch(0, 1, 8'h00, -1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      gi  = (r % 2 == 0) ? 0 : 2;
      mut = (gi == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 254)) : -1;
      launch(gi, int'($urandom_range(1, 3)), 8'($urandom_range(0, 255)), mut, 0, 0);
    end

    repeat (5) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
